nios2_oci_trace_capture: RTL and testbench
==========================================

NIOS2_OCI_TRACE_CAPTURE -- requirements
Module: nios2_oci_trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 30, meaning width of the debug capture word dct_buffer.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the dct_count tag stored with each word.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of entries; a power of two, minimum 2.
REQ-004 SHALL have parameter WRAP_MODE, default 0, meaning 0 = stop-on-full (drop new), 1 = ring (overwrite oldest).
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset_n  input  1  meaning reset, asynchronous and active-low.
REQ-007 SHALL have port dct_valid  input  1  meaning a capture word is present this cycle.
REQ-008 SHALL have port dct_buffer  input  DATA_W  meaning the capture data word.
REQ-009 SHALL have port dct_count  input  CNT_W  meaning the tag stored alongside dct_buffer.
REQ-010 SHALL have port test_ending  input  1  meaning stop capture (level or pulse).
REQ-011 SHALL have port test_has_ended  input  1  meaning the test is complete; allows transition to DONE.
REQ-012 SHALL have port clear  input  1  meaning synchronous flush and return to CAPTURE.
REQ-013 SHALL have port rd_req  input  1  meaning pop one entry.
REQ-014 SHALL have port rd_valid  output  1  meaning rd_data holds a popped entry this cycle.
REQ-015 SHALL have port rd_data  output  CNT_W+DATA_W  meaning {dct_count, dct_buffer} of the popped entry.
REQ-016 SHALL have port level  output  $clog2(DEPTH+1)  meaning current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  meaning a write was dropped (WRAP_MODE=0) since the last clear.
REQ-018 SHALL have port wrapped  output  1  meaning an entry was overwritten (WRAP_MODE=1) since the last clear.
REQ-019 SHALL have port state  output  2  meaning the FSM state encoding: CAPTURE=0, DRAIN=1, DONE=2.

Function
REQ-020 SHALL implement FSM CAPTURE -> DRAIN when test_ending=1; DRAIN -> DONE when test_has_ended=1 and level=0; any state -> CAPTURE when clear=1.
REQ-021 SHALL write an entry only in CAPTURE with dct_valid=1; test_ending=1 in the same cycle still accepts that cycle's word.
REQ-022 SHALL return rd_valid=1 with rd_data exactly one cycle after rd_req=1 with level>0; reads SHALL be honoured in all states.
REQ-023 SHALL ignore rd_req while level=0: no pointer change and rd_valid=0 in the next cycle.
REQ-024 SHALL accept a write with level=DEPTH and simultaneous pop in either mode; level is unchanged.
REQ-025 SHALL, with WRAP_MODE=0, level=DEPTH, write and no pop, drop the word and set overflow (sticky).
REQ-026 SHALL, with WRAP_MODE=1, level=DEPTH, write and no pop, overwrite the oldest entry, advance the read pointer, hold level=DEPTH, and set wrapped (sticky).
REQ-027 SHALL wrap pointers modulo DEPTH and keep level exact (+1 write only, -1 pop only, 0 both or neither).
REQ-028 SHALL give clear priority over all other inputs: level=0, pointers=0, overflow=wrapped=0, and any rd_valid for a read request made in the same cycle suppressed.
REQ-029 SHALL never change rd_data except in a cycle where rd_valid=1 is presented.

Reset
REQ-030 SHALL on reset_n=0 asynchronously force state=CAPTURE, level=0, pointers=0, rd_valid=0, rd_data=0, overflow=0, wrapped=0.
REQ-031 SHALL discard stored contents on reset mid-operation and SHALL NOT require the storage array itself to be reset.

Structure
REQ-032 SHALL place the state enum, its encodings and the parameter defaults in package nios2_oci_trace_pkg.
REQ-033 SHALL put storage in one sub-module nios2_oci_trace_ram (simple dual-port, registered read, no reset); pointer and FSM logic stay in the top level.

Verification
REQ-034 SHALL cover: DEPTH=4; write 0x1..0x3 with count 1..3; pop 3 times -> rd_data {1,0x1},{2,0x2},{3,0x3} on consecutive rd_valid cycles; level 3->0.
REQ-035 SHALL cover: WRAP_MODE=0, DEPTH=4; write 0xA..0xF -> level=4, overflow=1; pops return 0xA..0xD.
REQ-036 SHALL cover: WRAP_MODE=1, DEPTH=4; write 0xA..0xF -> level=4, wrapped=1; pops return 0xC..0xF.
REQ-037 SHALL cover: level=4 with simultaneous write 0x55 and pop -> popped word is the oldest entry, level stays 4, 0x55 is the last entry read out, and no flag is set.
REQ-038 SHALL cover: test_ending with 2 entries -> DRAIN; dct_valid ignored; 2 pops, then test_has_ended -> DONE; clear -> CAPTURE with level=0.
REQ-039 SHALL cover: reset_n asserted low mid-read with level=3 -> all outputs at REQ-030 values in the same cycle; the first pop after release reads nothing.

Source files
------------

// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the OCI trace capture buffer: FSM state encoding
// and parameter defaults.
package nios2_oci_trace_pkg;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } trace_state_e;

    localparam int DEF_DATA_W    = 30;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_WRAP_MODE = 0;

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// Simple dual-port storage for trace entries: one write port, one read port
// with a registered output that only updates when a read is enabled.
module nios2_oci_trace_ram #(
    parameter int WIDTH  = 34,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read-before-write: a same-address read returns the previous contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Debug trace capture FIFO with stop-on-full or ring behaviour and a
// CAPTURE/DRAIN/DONE sequencer driven by the test-end handshake.
module nios2_oci_trace_capture
    import nios2_oci_trace_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WRAP_MODE = DEF_WRAP_MODE
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         dct_valid,
    input  logic [DATA_W-1:0]            dct_buffer,
    input  logic [CNT_W-1:0]             dct_count,
    input  logic                         test_ending,
    input  logic                         test_has_ended,
    input  logic                         clear,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic [CNT_W+DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         wrapped,
    output logic [1:0]                   state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int RW = CNT_W + DATA_W;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    trace_state_e     r_state, w_state_next;
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_rd_valid, r_has_data, r_overflow, r_wrapped;
    logic             w_full, w_empty, w_wr_req, w_pop, w_push, w_overwrite, w_drop;
    logic [RW-1:0]    w_ram_q;

    assign w_full      = (r_level == FULL_LVL);
    assign w_empty     = (r_level == '0);
    assign w_wr_req    = (r_state == ST_CAPTURE) && dct_valid && !clear;
    assign w_pop       = rd_req && !w_empty && !clear;
    assign w_push      = w_wr_req && (!w_full || w_pop || (WRAP_MODE != 0));
    assign w_overwrite = w_wr_req && w_full && !w_pop && (WRAP_MODE != 0);
    assign w_drop      = w_wr_req && w_full && !w_pop && (WRAP_MODE == 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = ST_CAPTURE;
        end else begin
            unique case (r_state)
                ST_CAPTURE: if (test_ending) w_state_next = ST_DRAIN;
                ST_DRAIN:   if (test_has_ended && w_empty) w_state_next = ST_DONE;
                default:    w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_has_data <= 1'b0;
            r_overflow <= 1'b0;
            r_wrapped  <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
            r_wrapped  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            // An overwrite discards the oldest entry, so the read side skips it.
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop && !w_overwrite) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
            r_rd_valid <= w_pop;
            if (w_pop) begin
                r_has_data <= 1'b1;
            end
            r_overflow <= r_overflow | w_drop;
            r_wrapped  <= r_wrapped | w_overwrite;
        end
    end

    nios2_oci_trace_ram #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({dct_count, dct_buffer}),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // The RAM output register has no reset; mask it until the first pop.
    assign rd_data  = r_has_data ? w_ram_q : '0;
    assign rd_valid = r_rd_valid;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign wrapped  = r_wrapped;
    assign state    = r_state;

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Bench for the trace capture buffer: two DEPTH=4 instances (stop-on-full and
// ring) share stimulus and are checked every cycle against a list-based model.
module tb_nios2_oci_trace_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dct_valid, test_ending, test_has_ended, clear, rd_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    logic        d0_rv, d1_rv, d0_ov, d1_ov, d0_wr, d1_wr;
    logic [33:0] d0_rd, d1_rd;
    logic [2:0]  d0_lvl, d1_lvl;
    logic [1:0]  d0_st, d1_st;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    nios2_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(4), .WRAP_MODE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .clear(clear), .rd_req(rd_req), .rd_valid(d0_rv), .rd_data(d0_rd), .level(d0_lvl),
        .overflow(d0_ov), .wrapped(d0_wr), .state(d0_st));

    nios2_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(4), .WRAP_MODE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .clear(clear), .rd_req(rd_req), .rd_valid(d1_rv), .rd_data(d1_rd), .level(d1_lvl),
        .overflow(d1_ov), .wrapped(d1_wr), .state(d1_st));

    // Model: index 0 drops when full, index 1 overwrites the oldest.
    logic [33:0] mlist [2][4];
    int          mcnt  [2] = '{0, 0};
    logic        m_ov  [2] = '{1'b0, 1'b0};
    logic        m_wr  [2] = '{1'b0, 1'b0};
    logic        m_rv  [2] = '{1'b0, 1'b0};
    logic [33:0] m_rd  [2] = '{34'd0, 34'd0};
    logic [1:0]  m_st  [2] = '{2'd0, 2'd0};
    logic [1:0]  nst;
    logic        do_pop, do_wr;

    always @(posedge clk or negedge reset_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) begin
                mcnt[m] = 0; m_ov[m] = 1'b0; m_wr[m] = 1'b0;
                m_rv[m] = 1'b0; m_rd[m] = '0; m_st[m] = 2'd0;
            end else if (clear) begin
                mcnt[m] = 0; m_ov[m] = 1'b0; m_wr[m] = 1'b0;
                m_rv[m] = 1'b0; m_st[m] = 2'd0;
            end else begin
                nst = m_st[m];
                if (m_st[m] == 2'd0 && test_ending) nst = 2'd1;
                else if (m_st[m] == 2'd1 && test_has_ended && mcnt[m] == 0) nst = 2'd2;
                do_pop = rd_req && (mcnt[m] > 0);
                do_wr  = (m_st[m] == 2'd0) && dct_valid;
                m_rv[m] = do_pop;
                if (do_pop) begin
                    m_rd[m] = mlist[m][0];
                    for (int k = 0; k < 3; k++) mlist[m][k] = mlist[m][k+1];
                    mcnt[m]--;
                end
                if (do_wr) begin
                    if (mcnt[m] < 4) begin
                        mlist[m][mcnt[m]] = {dct_count, dct_buffer};
                        mcnt[m]++;
                    end else if (m == 1) begin
                        for (int k = 0; k < 3; k++) mlist[m][k] = mlist[m][k+1];
                        mlist[m][3] = {dct_count, dct_buffer};
                        m_wr[m] = 1'b1;
                    end else begin
                        m_ov[m] = 1'b1;
                    end
                end
                m_st[m] = nst;
            end
        end
    end

    task automatic check(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, m, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd_valid", 0, 64'(d0_rv),  64'(m_rv[0]));
            check("rd_valid", 1, 64'(d1_rv),  64'(m_rv[1]));
            check("rd_data",  0, 64'(d0_rd),  64'(m_rd[0]));
            check("rd_data",  1, 64'(d1_rd),  64'(m_rd[1]));
            check("level",    0, 64'(d0_lvl), 64'(mcnt[0]));
            check("level",    1, 64'(d1_lvl), 64'(mcnt[1]));
            check("overflow", 0, 64'(d0_ov),  64'(m_ov[0]));
            check("overflow", 1, 64'(d1_ov),  64'(m_ov[1]));
            check("wrapped",  0, 64'(d0_wr),  64'(m_wr[0]));
            check("wrapped",  1, 64'(d1_wr),  64'(m_wr[1]));
            check("state",    0, 64'(d0_st),  64'(m_st[0]));
            check("state",    1, 64'(d1_st),  64'(m_st[1]));
            if (d0_rv) $display("txn dut0 pop rd_data=%h level=%0d", d0_rd, d0_lvl);
            if (d1_rv) $display("txn dut1 pop rd_data=%h level=%0d", d1_rd, d1_lvl);
        end
    end

    task automatic drive(input logic v, input logic [29:0] b, input logic [3:0] c,
                         input logic rq, input logic te, input logic th, input logic cl);
        dct_valid = v; dct_buffer = b; dct_count = c; rd_req = rq;
        test_ending = te; test_has_ended = th; clear = cl;
        @(negedge clk);
    endtask

    task automatic wr(input int v);
        drive(1'b1, 30'(v), 4'(v), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic pop();
        drive(1'b0, 30'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic clr();
        drive(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic idle();
        drive(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [63:0] ent(input int v);
        logic [33:0] e;
        e = {4'(v), 30'(v)};
        return 64'(e);
    endfunction

    task automatic chk_both(input string name, input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] exp);
        check(name, 0, a0, exp);
        check(name, 1, a1, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
        test_ending = 1'b0; test_has_ended = 1'b0; clear = 1'b0; rd_req = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_both("rst_level", 64'(d0_lvl), 64'(d1_lvl), 64'd0);
        chk_both("rst_state", 64'(d0_st), 64'(d1_st), 64'd0);
        chk_both("rst_rd_valid", 64'(d0_rv), 64'(d1_rv), 64'd0);
        chk_both("rst_rd_data", 64'(d0_rd), 64'(d1_rd), 64'd0);
        cmp_en = 1'b1;

        // Basic ordering: three entries out in order, level 3 -> 0.
        clr();
        wr(1); wr(2); wr(3);
        chk_both("basic_level3", 64'(d0_lvl), 64'(d1_lvl), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            pop();
            chk_both("basic_rv", 64'(d0_rv), 64'(d1_rv), 64'd1);
            chk_both("basic_data", 64'(d0_rd), 64'(d1_rd), ent(i));
        end
        chk_both("basic_level0", 64'(d0_lvl), 64'(d1_lvl), 64'd0);

        // Fill past capacity: drop vs overwrite.
        clr();
        for (int v = 'hA; v <= 'hF; v++) wr(v);
        check("full_level", 0, 64'(d0_lvl), 64'd4);
        check("full_level", 1, 64'(d1_lvl), 64'd4);
        check("full_overflow", 0, 64'(d0_ov), 64'd1);
        check("full_wrapped", 0, 64'(d0_wr), 64'd0);
        check("full_wrapped", 1, 64'(d1_wr), 64'd1);
        check("full_overflow", 1, 64'(d1_ov), 64'd0);
        for (int i = 0; i < 4; i++) begin
            pop();
            check("full_pop", 0, 64'(d0_rd), ent('hA + i));
            check("full_pop", 1, 64'(d1_rd), ent('hC + i));
        end
        pop();
        chk_both("empty_pop_rv", 64'(d0_rv), 64'(d1_rv), 64'd0);
        check("empty_pop_hold", 0, 64'(d0_rd), ent('hD));
        check("empty_pop_hold", 1, 64'(d1_rd), ent('hF));

        // Full with simultaneous write and pop.
        clr();
        for (int v = 1; v <= 4; v++) wr(v);
        drive(1'b1, 30'h55, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_both("wp_data", 64'(d0_rd), 64'(d1_rd), ent(1));
        chk_both("wp_level", 64'(d0_lvl), 64'(d1_lvl), 64'd4);
        chk_both("wp_overflow", 64'(d0_ov), 64'(d1_ov), 64'd0);
        chk_both("wp_wrapped", 64'(d0_wr), 64'(d1_wr), 64'd0);
        for (int i = 2; i <= 4; i++) begin
            pop();
            chk_both("wp_drain", 64'(d0_rd), 64'(d1_rd), ent(i));
        end
        pop();
        chk_both("wp_last", 64'(d0_rd), 64'(d1_rd), ent('h55));

        // Sequencer: CAPTURE -> DRAIN -> DONE -> CAPTURE.
        clr();
        wr(6); wr(7);
        drive(1'b0, 30'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_both("fsm_drain", 64'(d0_st), 64'(d1_st), 64'd1);
        wr(8);
        chk_both("fsm_nowrite", 64'(d0_lvl), 64'(d1_lvl), 64'd2);
        pop();
        chk_both("fsm_pop1", 64'(d0_rd), 64'(d1_rd), ent(6));
        pop();
        chk_both("fsm_pop2", 64'(d0_rd), 64'(d1_rd), ent(7));
        chk_both("fsm_still_drain", 64'(d0_st), 64'(d1_st), 64'd1);
        drive(1'b0, 30'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_both("fsm_done", 64'(d0_st), 64'(d1_st), 64'd2);
        clr();
        chk_both("fsm_clear_state", 64'(d0_st), 64'(d1_st), 64'd0);
        chk_both("fsm_clear_level", 64'(d0_lvl), 64'(d1_lvl), 64'd0);

        // Asynchronous reset in the middle of a read burst.
        for (int v = 1; v <= 4; v++) wr(v);
        pop();
        chk_both("prerst_level", 64'(d0_lvl), 64'(d1_lvl), 64'd3);
        rd_req = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk_both("arst_level", 64'(d0_lvl), 64'(d1_lvl), 64'd0);
        chk_both("arst_rv", 64'(d0_rv), 64'(d1_rv), 64'd0);
        chk_both("arst_data", 64'(d0_rd), 64'(d1_rd), 64'd0);
        chk_both("arst_state", 64'(d0_st), 64'(d1_st), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pop();
        chk_both("postrst_rv", 64'(d0_rv), 64'(d1_rv), 64'd0);
        chk_both("postrst_level", 64'(d0_lvl), 64'(d1_lvl), 64'd0);

        // Randomised traffic, alternating write-heavy and read-heavy phases.
        for (int cyc = 0; cyc < 800; cyc++) begin
            int wp;
            wp = ((cyc / 100) % 2 == 0) ? 70 : 30;
            drive($urandom_range(0, 99) < wp, 30'($urandom), 4'($urandom),
                  $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 3);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
